board_scanner: RTL and testbench



---
 rtl/board_scanner_if.sv | 23 ++
 rtl/board_scanner.sv | 159 +++++++++++++++
 tb/tb_board_scanner.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_scanner_if.sv
// Scanner-side bundle: request/result handshake plus the board store read port.
// The master modport is the scanner itself; the slave side is controller + store.
interface board_scanner_if;
    logic       start;
    logic [2:0] rd_sel;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       valid;
    logic [2:0] err_row;
    logic [1:0] err_code;
    logic [6:0] queen_cnt;

    modport master (
        input  start, rd_data,
        output rd_sel, busy, done, valid, err_row, err_code, queen_cnt
    );

    modport slave (
        output start, rd_data,
        input  rd_sel, busy, done, valid, err_row, err_code, queen_cnt
    );
endinterface

// File: rtl/board_scanner.sv
// Walks the 8x8 queen board through the store's registered read port and
// reports whether it is a legal eight-queen placement, plus first offender.
module board_scanner #(
    parameter bit REQUIRE_FULL = 1'b1
) (
    input logic             clk,
    input logic             rst,
    board_scanner_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  rd_sel;
    logic        iss_v;
    logic        cap_v;
    logic [2:0]  cap_row;
    logic [3:0]  row4;

    logic [7:0]  col_mask;
    logic [14:0] diag;
    logic [14:0] anti;

    logic        valid;
    logic [2:0]  err_row;
    logic [1:0]  err_code;
    logic [6:0]  queen_cnt;

    logic [3:0]  n;
    logic        col_hit;
    logic        dia_hit;
    logic        row_bad;
    logic [1:0]  row_code;
    logic [1:0]  fold_code;
    logic [14:0] diag_nxt;
    logic [14:0] anti_nxt;

    logic        accept;

    assign accept = (state == IDLE) && bus.start;
    assign row4   = {1'b0, cap_row};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SCAN;
            SCAN:    if (cap_v && cap_row == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SCAN);
        bus.done = (state == DONE);
    end

    // Clash checks look only at masks from earlier rows; the row's own bits
    // are folded into the next-state masks.
    always_comb begin
        n        = 4'd0;
        dia_hit  = 1'b0;
        diag_nxt = diag;
        anti_nxt = anti;
        for (int c = 0; c < 8; c++) begin
            if (bus.rd_data[c]) begin
                n = n + 4'd1;
                if (diag[row4 + 4'd7 - 4'(c)] || anti[row4 + 4'(c)]) begin
                    dia_hit = 1'b1;
                end
                diag_nxt[row4 + 4'd7 - 4'(c)] = 1'b1;
                anti_nxt[row4 + 4'(c)]        = 1'b1;
            end
        end
        col_hit = |(bus.rd_data & col_mask);
        row_bad = (n > 4'd1) || ((n == 4'd0) && REQUIRE_FULL);
        if (row_bad) begin
            row_code = 2'b01;
        end else if (col_hit) begin
            row_code = 2'b10;
        end else if (dia_hit) begin
            row_code = 2'b11;
        end else begin
            row_code = 2'b00;
        end
        fold_code = (err_code != 2'b00) ? err_code : row_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel    <= 3'd0;
            iss_v     <= 1'b0;
            cap_v     <= 1'b0;
            cap_row   <= 3'd0;
            col_mask  <= 8'd0;
            diag      <= 15'd0;
            anti      <= 15'd0;
            valid     <= 1'b0;
            err_row   <= 3'd0;
            err_code  <= 2'b00;
            queen_cnt <= 7'd0;
        end else if (accept) begin
            rd_sel    <= 3'd0;
            iss_v     <= 1'b1;
            cap_v     <= 1'b0;
            cap_row   <= 3'd0;
            col_mask  <= 8'd0;
            diag      <= 15'd0;
            anti      <= 15'd0;
            valid     <= 1'b0;
            err_row   <= 3'd0;
            err_code  <= 2'b00;
            queen_cnt <= 7'd0;
        end else if (state == SCAN) begin
            if (iss_v && rd_sel != 3'd7) begin
                rd_sel <= rd_sel + 3'd1;
            end else begin
                iss_v <= 1'b0;
            end
            // cap_v/cap_row tag the row the store returns one edge later
            cap_v   <= iss_v;
            cap_row <= rd_sel;
            if (cap_v) begin
                col_mask  <= col_mask | bus.rd_data;
                diag      <= diag_nxt;
                anti      <= anti_nxt;
                queen_cnt <= queen_cnt + 7'(n);
                if (err_code == 2'b00 && row_code != 2'b00) begin
                    err_code <= row_code;
                    err_row  <= cap_row;
                end
                if (cap_row == 3'd7) begin
                    valid <= (fold_code == 2'b00);
                end
            end
        end
    end

    assign bus.rd_sel    = rd_sel;
    assign bus.valid     = valid;
    assign bus.err_row   = err_row;
    assign bus.err_code  = err_code;
    assign bus.queen_cnt = queen_cnt;

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: two instances (full / partial board rules) read a
// shared board store model and are checked against a pairwise queen model.
module tb_board_scanner;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    board_scanner_if bf();
    board_scanner_if bp();

    assign bf.start = start;
    assign bp.start = start;

    logic [7:0] mem [8];

    always @(posedge clk) begin
        bf.rd_data <= mem[bf.rd_sel];
        bp.rd_data <= mem[bp.rd_sel];
    end

    board_scanner #(.REQUIRE_FULL(1'b1)) dut_f (
        .clk(clk),
        .rst(rst),
        .bus(bf.master)
    );

    board_scanner #(.REQUIRE_FULL(1'b0)) dut_p (
        .clk(clk),
        .rst(rst),
        .bus(bp.master)
    );

    int total = 0;
    int bad   = 0;

    // Pairwise view: every queen is compared with every queen on earlier rows.
    function automatic void model(input bit full, output logic [2:0] er,
                                  output logic [1:0] ec, output logic [6:0] qc);
        int n;
        int code;
        bit cc;
        bit dc;
        er = 3'd0;
        ec = 2'd0;
        qc = 7'd0;
        for (int r = 0; r < 8; r++) begin
            n  = $countones(mem[r]);
            qc = qc + 7'(n);
            cc = 1'b0;
            dc = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (mem[r][c]) begin
                    for (int r2 = 0; r2 < r; r2++) begin
                        for (int c2 = 0; c2 < 8; c2++) begin
                            if (mem[r2][c2]) begin
                                if (c2 == c) cc = 1'b1;
                                else if (r - r2 == c - c2 || r - r2 == c2 - c) dc = 1'b1;
                            end
                        end
                    end
                end
            end
            code = (n > 1 || (n == 0 && full)) ? 1 : cc ? 2 : dc ? 3 : 0;
            if (ec == 2'd0 && code != 0) begin
                ec = 2'(code);
                er = 3'(r);
            end
        end
    endfunction

    task automatic do_scan(input string name);
        logic [2:0] er_f, er_p;
        logic [1:0] ec_f, ec_p;
        logic [6:0] qc_f, qc_p;
        int done_at;
        int dcnt;
        int pdone_at;
        model(1'b1, er_f, ec_f, qc_f);
        model(1'b0, er_p, ec_p, qc_p);
        done_at  = -1;
        pdone_at = -1;
        dcnt     = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 7) begin
                total++;
                if (bf.rd_sel !== 3'(k)) begin
                    bad++;
                    $display("FAIL %s.rd_sel edge=%0d got=%0d exp=%0d", name, k, bf.rd_sel, k);
                end
            end
            if (k == 8) begin
                total++;
                if (bf.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s.busy got=%b exp=1", name, bf.busy);
                end
            end
            if (bf.done === 1'b1) begin
                dcnt++;
                if (done_at < 0) done_at = k;
            end
            if (bp.done === 1'b1 && pdone_at < 0) pdone_at = k;
        end
        total++;
        if (done_at != 9 || dcnt != 1 || pdone_at != 9) begin
            bad++;
            $display("FAIL %s.done_latency got=%0d/%0d cnt=%0d exp=9/9 cnt=1",
                     name, done_at, pdone_at, dcnt);
        end
        total++;
        if ({bf.valid, bf.err_code, bf.err_row, bf.queen_cnt} !==
            {ec_f == 2'd0, ec_f, er_f, qc_f}) begin
            bad++;
            $display("FAIL %s.full got v=%b c=%0d r=%0d q=%0d exp v=%b c=%0d r=%0d q=%0d",
                     name, bf.valid, bf.err_code, bf.err_row, bf.queen_cnt,
                     ec_f == 2'd0, ec_f, er_f, qc_f);
        end
        total++;
        if ({bp.valid, bp.err_code, bp.err_row, bp.queen_cnt} !==
            {ec_p == 2'd0, ec_p, er_p, qc_p}) begin
            bad++;
            $display("FAIL %s.partial got v=%b c=%0d r=%0d q=%0d exp v=%b c=%0d r=%0d q=%0d",
                     name, bp.valid, bp.err_code, bp.err_row, bp.queen_cnt,
                     ec_p == 2'd0, ec_p, er_p, qc_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bf.rd_sel, bf.busy, bf.done, bf.valid, bf.err_row, bf.err_code, bf.queen_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL reset got=%h exp=0",
                     {bf.rd_sel, bf.busy, bf.done, bf.valid, bf.err_row, bf.err_code, bf.queen_cnt});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        mem = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
        do_scan("legal");
        mem[5] = 8'h01;
        do_scan("col_row5");
        mem = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_scan("diag_row1");
        mem = '{8'h01, 8'h10, 8'h80, 8'h00, 8'h04, 8'h40, 8'h02, 8'h08};
        do_scan("empty_row3");
        mem = '{8'h01, 8'h10, 8'h83, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
        do_scan("double_row2");
        mem = '{default: 8'h00};
        do_scan("empty_board");
        mem = '{default: 8'hff};
        do_scan("full_board");
    endtask

    task automatic test_random();
        int perm[8];
        int j;
        int t;
        int mode;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j       = int'($urandom_range(i, 0));
                t       = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int r = 0; r < 8; r++) mem[r] = 8'(1 << perm[r]);
            mode = int'($urandom_range(3, 0));
            if (mode == 1) mem[$urandom_range(7, 0)] = 8'($urandom);
            if (mode == 2) mem[$urandom_range(7, 0)] = 8'h00;
            if (mode == 3) begin
                for (int r = 0; r < 8; r++) mem[r] = 8'($urandom & $urandom);
            end
            do_scan($sformatf("rand%0d", it));
        end
    endtask

    task automatic test_busy_start();
        int dcnt;
        int first;
        mem   = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
        dcnt  = 0;
        first = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge clk);
            if (bf.done === 1'b1) begin
                dcnt++;
                if (first < 0) first = k;
            end
            start = (k >= 2 && k <= 4) || k == 9;
        end
        start = 1'b0;
        total++;
        if (dcnt != 1 || first != 9) begin
            bad++;
            $display("FAIL busy_start dones=%0d first=%0d exp dones=1 first=9", dcnt, first);
        end
    endtask

    task automatic test_back_to_back();
        int dcnt;
        int second;
        dcnt   = 0;
        second = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (bf.done === 1'b1) begin
                dcnt++;
                if (dcnt == 2) second = k;
            end
            if (k == 20) start = 1'b0;
        end
        total++;
        if (dcnt != 2 || second != 20) begin
            bad++;
            $display("FAIL back_to_back dones=%0d second=%0d exp dones=2 second=20", dcnt, second);
        end
    endtask

    task automatic test_mid_reset();
        int dcnt;
        mem = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_scan("pre_reset");
        dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bf.rd_sel, bf.busy, bf.done, bf.valid, bf.err_row, bf.err_code, bf.queen_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=0",
                     {bf.rd_sel, bf.busy, bf.done, bf.valid, bf.err_row, bf.err_code, bf.queen_cnt});
        end
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bf.done === 1'b1 || bf.busy === 1'b1) dcnt++;
        end
        total++;
        if (dcnt != 0) begin
            bad++;
            $display("FAIL mid_reset_quiet active_cycles=%0d exp=0", dcnt);
        end
    endtask

    initial begin
        mem = '{default: 8'h00};
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
